// File: rtl/mmio_write_router.sv
// Routes MEM-stage stores either to data memory or to one-entry per-channel MMIO write buffers.
// Define MMIO_WR_UNMAPPED_CNT_EN to build the saturating counter of dropped unmapped writes.
module mmio_write_router #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int NCH      = 4,
  parameter int DEC_BITS = 12,
  parameter logic [NCH*DEC_BITS-1:0] CH_BASE = {12'h81c, 12'h814, 12'h804, 12'hf04}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic                  we,
  output logic                  dmem_we,
  output logic                  stall,
  output logic [NCH-1:0]        ch_valid,
  output logic [NCH*DATA_W-1:0] ch_data,
  input  logic [NCH-1:0]        ch_ready,
  output logic [15:0]           unmapped_cnt
);

  logic                  win;
  logic [NCH-1:0]        match;
  logic [NCH-1:0]        sel;
  logic [NCH-1:0]        accept;
  logic [NCH-1:0]        valid_q, valid_d;
  logic [NCH*DATA_W-1:0] data_q, data_d;
  logic                  unused_addr_hi;

  assign win            = addr[DEC_BITS-1];
  assign unused_addr_hi = ^addr[ADDR_W-1:DEC_BITS];

  always_comb begin
    match = '0;
    for (int i = 0; i < NCH; i++) begin
      match[i] = win & (addr[DEC_BITS-1:0] == CH_BASE[i*DEC_BITS +: DEC_BITS]);
    end
  end

  // Duplicate bases resolve to the lowest channel index.
  always_comb begin
    logic found;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (match[i] && !found) begin
        sel[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  assign accept  = {NCH{we}} & sel & (~valid_q | ch_ready);
  assign stall   = |({NCH{we}} & sel & valid_q & ~ch_ready);
  assign dmem_we = we & ~win;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int i = 0; i < NCH; i++) begin
      if (accept[i]) begin
        valid_d[i]                  = 1'b1;
        data_d[i*DATA_W +: DATA_W]  = wdata;
      end else if (ch_ready[i]) begin
        valid_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign ch_valid = valid_q;
  assign ch_data  = data_q;

`ifdef MMIO_WR_UNMAPPED_CNT_EN
  logic        unmapped;
  logic [15:0] cnt_q, cnt_d;

  assign unmapped = we & win & ~(|match);

  always_comb begin
    cnt_d = cnt_q;
    if (unmapped && (cnt_q != 16'hffff)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign unmapped_cnt = cnt_q;
`else
  assign unmapped_cnt = 16'h0000;
`endif

endmodule

// File: doc/mmio_write_router.md
MMIO_WRITE_ROUTER -- requirements
Module: mmio_write_router

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  ADDR_W, 32, CPU store address width
  DATA_W, 32, store data width
  NCH, 4, number of peripheral write channels (1..8)
  DEC_BITS, 12, low address bits used for decode
  CH_BASE, {12'h81c,12'h814,12'h804,12'hf04}, packed NCH*DEC_BITS match values, channel 0 in LSBs
REQ-002 Ports SHALL be (name, direction, width, meaning), clock and reset first:
  clk  in  1  single clock; all state updates on the rising edge
  rst_n  in  1  asynchronous, active-low reset
  addr  in  ADDR_W  MEM-stage store address
  wdata  in  DATA_W  MEM-stage store data
  we  in  1  MEM-stage store enable
  dmem_we  out  1  data-memory write enable
  stall  out  1  hold request to CPU pipeline
  ch_valid  out  NCH  per-channel pending-write valid
  ch_data  out  NCH*DATA_W  per-channel buffered write data
  ch_ready  in  NCH  per-channel peripheral accept
  unmapped_cnt  out  16  count of dropped unmapped writes (macro-dependent, REQ-017)

Function
REQ-003 Window hit SHALL be win = addr[DEC_BITS-1]; channel i match SHALL be win & (addr[DEC_BITS-1:0] == CH_BASE[i]); only the lowest matching index SHALL be selected on duplicate bases.
REQ-004 dmem_we SHALL equal we & ~win, combinationally, zero latency, and SHALL never be affected by stall.
REQ-005 Each channel SHALL hold a one-entry buffer (valid bit plus DATA_W data register).
REQ-006 Accept: when we & match i & (~ch_valid[i] | ch_ready[i]), ch_valid[i] SHALL be 1 and ch_data[i] SHALL equal wdata on the next cycle (latency 1).
REQ-007 Drain: ch_valid[i] & ch_ready[i] SHALL clear ch_valid[i] on the next edge unless an accept to channel i occurs the same cycle, in which case valid stays 1 and data is replaced.
REQ-008 stall SHALL equal we & match i & ch_valid[i] & ~ch_ready[i], combinational; the CPU holds addr/wdata/we stable while stall=1; the write is accepted in the first cycle stall=0.
REQ-009 ch_data[i] SHALL be stable while ch_valid[i]=1 and ch_ready[i]=0.
REQ-010 Unmapped write (we & win & no match) SHALL be dropped: no dmem_we, no channel update, no stall.
REQ-011 we=0 SHALL cause no state change other than drains.
REQ-012 Channels SHALL be independent; a stall on channel j SHALL not block drains on any channel.

Reset
REQ-013 rst_n low SHALL asynchronously clear all ch_valid, all ch_data to 0 and unmapped_cnt to 0.
REQ-014 A write buffered but not drained at reset assertion SHALL be discarded.
REQ-015 Outputs dmem_we and stall SHALL remain combinational during reset; the bench SHALL hold we=0 during reset.

Configuration
REQ-016 Macro MMIO_WR_UNMAPPED_CNT_EN SHALL select the unmapped-write counter.
REQ-017 With the macro defined, unmapped_cnt SHALL increment by 1 per cycle satisfying REQ-010 and saturate at 16'hffff; without it, unmapped_cnt SHALL be tied to 0 and no counter flops exist.

Verification (NCH=2, CH_BASE={12'h804,12'hf04}, macro defined)
REQ-018 we=1, addr=0x0000_0100, wdata=0x11 -> dmem_we=1 same cycle; ch_valid=2'b00; stall=0.
REQ-019 we=1, addr=0x1001_0f04, wdata=0xABCD, ch_ready=0 -> dmem_we=0; next cycle ch_valid[0]=1, ch_data[0]=0xABCD.
REQ-020 Second write to 0xf04 (wdata=0x1234) with ch_ready[0]=0 -> stall=1 while ch_ready[0]=0; raise ch_ready[0] -> stall=0 that cycle, next cycle ch_data[0]=0x1234, ch_valid[0]=1.
REQ-021 we=1, addr=0x0000_0a00 -> dmem_we=0, stall=0, ch_valid unchanged, unmapped_cnt 0->1; 65536 such writes -> unmapped_cnt=16'hffff.
REQ-022 Channel 1 pending (0x804, wdata=0x5), pull rst_n low mid-cycle -> ch_valid=2'b00, ch_data=0, unmapped_cnt=0 immediately, no wait for clk.
REQ-023 Simultaneous: ch_valid[1]=1, ch_ready[1]=1, we=1 to 0x804 wdata=0x7 -> stall=0, next cycle ch_valid[1]=1, ch_data[1]=0x7.
